// File: rtl/vwiden_pkg.sv
// Shared vALU definitions for the sequenced operand-widening stage.
package vwiden_pkg;

  typedef enum logic [1:0] {SEW_8 = 2'd0, SEW_16 = 2'd1, SEW_32 = 2'd2, SEW_64 = 2'd3} sew_e;

  typedef enum logic [0:0] {IDLE = 1'b0, EMIT = 1'b1} state_e;

  localparam logic [0:0] ST_IDLE = IDLE;
  localparam logic [0:0] ST_EMIT = EMIT;

  function automatic logic [1:0] log2_factor(input logic factor);
    return factor ? 2'd2 : 2'd1;
  endfunction

  function automatic logic [1:0] last_idx(input logic factor);
    return factor ? 2'd3 : 2'd1;
  endfunction

endpackage

// File: rtl/vwiden_if.sv
// Source-beat and widened-beat handshake bundle for vwiden_seq.
interface vwiden_if #(
  parameter int DATA_WIDTH = 64,
  parameter int SEW_WIDTH  = 2,
  parameter int BE_WIDTH   = DATA_WIDTH / 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_vec0;
  logic [DATA_WIDTH-1:0] in_vec1;
  logic [SEW_WIDTH-1:0]  in_sew;
  logic                  in_factor;
  logic                  in_signed0;
  logic                  in_signed1;
  logic [BE_WIDTH-1:0]   in_be;
  logic                  in_flush;

  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_vec0;
  logic [DATA_WIDTH-1:0] out_vec1;
  logic [BE_WIDTH-1:0]   out_be;
  logic [SEW_WIDTH-1:0]  out_sew;
  logic [1:0]            out_idx;
  logic                  out_last;
  logic                  out_err;

  modport master (
    output in_valid, in_vec0, in_vec1, in_sew, in_factor, in_signed0, in_signed1,
           in_be, in_flush, out_ready,
    input  in_ready, out_valid, out_vec0, out_vec1, out_be, out_sew, out_idx,
           out_last, out_err
  );

  modport slave (
    input  in_valid, in_vec0, in_vec1, in_sew, in_factor, in_signed0, in_signed1,
           in_be, in_flush, out_ready,
    output in_ready, out_valid, out_vec0, out_vec1, out_be, out_sew, out_idx,
           out_last, out_err
  );
endinterface

// File: rtl/vwiden_slice.sv
// Combinational element widener: extends every SEW element of one slice to SEW*F bits.
module vwiden_slice #(
  parameter int DATA_WIDTH = 64,
  parameter int SEW_WIDTH  = 2
) (
  input  logic [DATA_WIDTH/2-1:0] slice,
  input  logic [SEW_WIDTH-1:0]    sew,
  input  logic                    factor,
  input  logic                    sgn,
  output logic [DATA_WIDTH-1:0]   wide
);
  // One candidate per (factor, sew); combinations that do not fit the word stay zero.
  logic [1:0][3:0][DATA_WIDTH-1:0] cand;

  for (genvar f = 0; f < 2; f++) begin : g_f
    for (genvar g = 0; g < 4; g++) begin : g_sew
      localparam int EW = 8 << g;
      localparam int OW = EW << (f + 1);
      localparam int NE = DATA_WIDTH / OW;
      if (NE == 0) begin : g_none
        assign cand[f][g] = '0;
      end else begin : g_ext
        for (genvar e = 0; e < NE; e++) begin : g_el
          assign cand[f][g][e*OW +: OW] =
            {{(OW-EW){sgn & slice[e*EW+EW-1]}}, slice[e*EW +: EW]};
        end
        if (NE * OW < DATA_WIDTH) begin : g_pad
          assign cand[f][g][DATA_WIDTH-1:NE*OW] = '0;
        end
      end
    end
  end

  assign wide = cand[factor][sew];

endmodule

// File: rtl/vwiden_seq.sv
// Sequenced widening stage: one source beat in, F registered widened beats out.
module vwiden_seq
  import vwiden_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int SEW_WIDTH  = 2,
  parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
  input logic     clk,
  input logic     rst_n,
  vwiden_if.slave bus
);
  localparam int HALF = DATA_WIDTH / 2;
  localparam int QTR  = DATA_WIDTH / 4;
  localparam int BEH  = BE_WIDTH / 2;
  localparam int BEQ  = BE_WIDTH / 4;

  logic [0:0]                 state;
  logic [1:0]                 idx;
  logic [1:0][DATA_WIDTH-1:0] hold_vec;
  logic [SEW_WIDTH-1:0]       hold_sew;
  logic                       hold_factor;
  logic [1:0]                 hold_sgn;
  logic [BE_WIDTH-1:0]        hold_be;

  logic [1:0][DATA_WIDTH-1:0] out_vec_q;
  logic [BE_WIDTH-1:0]        out_be_q;
  logic [SEW_WIDTH-1:0]       out_sew_q;
  logic                       out_last_q;
  logic                       out_err_q;

  logic emit, done, adv, rdy, acc;

  assign emit = (state == ST_EMIT);
  assign done = emit & bus.out_ready & out_last_q;
  assign adv  = emit & bus.out_ready & ~out_last_q & ~bus.in_flush;
  assign rdy  = ~bus.in_flush & (~emit | done);
  assign acc  = bus.in_valid & rdy;

  // Next beat comes from the incoming word on accept, else from the held word at idx+1.
  logic [1:0][DATA_WIDTH-1:0] src_vec;
  logic [SEW_WIDTH-1:0]       src_sew;
  logic                       src_factor;
  logic [1:0]                 src_sgn;
  logic [BE_WIDTH-1:0]        src_be;
  logic [1:0]                 src_k;

  always_comb begin
    src_vec    = hold_vec;
    src_sew    = hold_sew;
    src_factor = hold_factor;
    src_sgn    = hold_sgn;
    src_be     = hold_be;
    src_k      = idx + 2'd1;
    if (acc) begin
      src_vec    = {bus.in_vec1, bus.in_vec0};
      src_sew    = bus.in_sew;
      src_factor = bus.in_factor;
      src_sgn    = {bus.in_signed1, bus.in_signed0};
      src_be     = bus.in_be;
      src_k      = 2'd0;
    end
  end

  logic [1:0][DATA_WIDTH-1:0] wide;

  for (genvar op = 0; op < 2; op++) begin : g_op
    logic [1:0][HALF-1:0] halves;
    logic [3:0][QTR-1:0]  quarters;
    logic [HALF-1:0]      slice;
    assign halves   = src_vec[op];
    assign quarters = src_vec[op];
    assign slice    = src_factor ? HALF'(quarters[src_k]) : halves[src_k[0]];
    vwiden_slice #(.DATA_WIDTH(DATA_WIDTH), .SEW_WIDTH(SEW_WIDTH)) u_slice (
      .slice  (slice),
      .sew    (src_sew),
      .factor (src_factor),
      .sgn    (src_sgn[op]),
      .wide   (wide[op])
    );
  end

  logic [1:0][BEH-1:0] be_h;
  logic [3:0][BEQ-1:0] be_q;
  logic [BE_WIDTH-1:0] be2, be4;
  assign be_h = src_be;
  assign be_q = src_be;

  for (genvar j = 0; j < BEH; j++) begin : g_be2
    assign be2[2*j +: 2] = {2{be_h[src_k[0]][j]}};
  end
  for (genvar j = 0; j < BEQ; j++) begin : g_be4
    assign be4[4*j +: 4] = {4{be_q[src_k][j]}};
  end

  logic [SEW_WIDTH:0] sew_sum;
  logic               src_err, src_last;
  assign sew_sum  = {1'b0, src_sew} + (SEW_WIDTH+1)'(log2_factor(src_factor));
  assign src_err  = sew_sum > (SEW_WIDTH+1)'(SEW_64);
  assign src_last = src_err | (src_k == last_idx(src_factor));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_vec    <= '0;
      hold_sew    <= '0;
      hold_factor <= 1'b0;
      hold_sgn    <= '0;
      hold_be     <= '0;
    end else if (acc) begin
      hold_vec    <= {bus.in_vec1, bus.in_vec0};
      hold_sew    <= bus.in_sew;
      hold_factor <= bus.in_factor;
      hold_sgn    <= {bus.in_signed1, bus.in_signed0};
      hold_be     <= bus.in_be;
    end
  end

  // Flush has priority over any handshake seen in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      idx        <= '0;
      out_vec_q  <= '0;
      out_be_q   <= '0;
      out_sew_q  <= '0;
      out_last_q <= 1'b0;
      out_err_q  <= 1'b0;
    end else if (bus.in_flush) begin
      state      <= ST_IDLE;
      idx        <= '0;
      out_vec_q  <= '0;
      out_be_q   <= '0;
      out_sew_q  <= '0;
      out_last_q <= 1'b0;
      out_err_q  <= 1'b0;
    end else if (acc || adv) begin
      state      <= ST_EMIT;
      idx        <= src_k;
      out_vec_q  <= src_err ? '0 : wide;
      out_be_q   <= src_err ? '0 : (src_factor ? be4 : be2);
      out_sew_q  <= src_err ? src_sew : sew_sum[SEW_WIDTH-1:0];
      out_last_q <= src_last;
      out_err_q  <= src_err;
    end else if (done) begin
      state      <= ST_IDLE;
      idx        <= '0;
      out_vec_q  <= '0;
      out_be_q   <= '0;
      out_sew_q  <= '0;
      out_last_q <= 1'b0;
      out_err_q  <= 1'b0;
    end
  end

  assign bus.in_ready  = rdy;
  assign bus.out_valid = emit;
  assign bus.out_vec0  = out_vec_q[0];
  assign bus.out_vec1  = out_vec_q[1];
  assign bus.out_be    = out_be_q;
  assign bus.out_sew   = out_sew_q;
  assign bus.out_idx   = idx;
  assign bus.out_last  = out_last_q;
  assign bus.out_err   = out_err_q;

endmodule

// File: tb/tb_vwiden_seq.sv
// Scoreboard bench for vwiden_seq: directed words, stalls, flush and mid-word reset.
module tb_vwiden_seq;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  vwiden_if #(.DATA_WIDTH(64), .SEW_WIDTH(2)) bus ();

  vwiden_seq #(.DATA_WIDTH(64), .SEW_WIDTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [63:0] v0;
    logic [63:0] v1;
    logic [7:0]  be;
    logic [1:0]  sew;
    logic [1:0]  idx;
    logic        last;
    logic        err;
  } beat_t;

  beat_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    rdy_mode = 0;
  logic  acc_ov, acc_last;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, want, $time);
    end
  endtask

  task automatic push(input logic [63:0] v0, input logic [63:0] v1, input logic [7:0] be,
                      input logic [1:0] sew, input logic [1:0] idx, input logic last,
                      input logic err);
    exp_q.push_back('{v0, v1, be, sew, idx, last, err});
  endtask

  task automatic send(input logic [63:0] v0, input logic [63:0] v1, input logic [1:0] sew,
                      input logic f, input logic s0, input logic s1, input logic [7:0] be);
    bit ok;
    ok = 1'b0;
    bus.in_vec0 = v0;    bus.in_vec1 = v1;   bus.in_sew = sew;  bus.in_factor = f;
    bus.in_signed0 = s0; bus.in_signed1 = s1; bus.in_be = be;   bus.in_valid = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        acc_ov = bus.out_valid;
        acc_last = bus.out_last;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready never seen, required 1");
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    @(posedge clk); #1;
    while ((exp_q.size() != 0 || bus.out_valid) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_left", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      bus.out_ready = (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: pops the scoreboard on every accepted beat, checks stall stability and in_ready.
  beat_t cur, snap, e;
  bit    stalled = 1'b0;
  always @(negedge clk) begin
    if (!rst_n || bus.in_flush) begin
      stalled = 1'b0;
    end else if (bus.out_valid) begin
      cur = '{bus.out_vec0, bus.out_vec1, bus.out_be, bus.out_sew, bus.out_idx,
              bus.out_last, bus.out_err};
      chk("in_ready_rule", 64'(bus.in_ready), 64'(bus.out_ready & bus.out_last));
      if (stalled) begin
        checks++;
        if (cur !== snap) begin
          errors++;
          $display("FAIL stall_hold: got %h expected %h", cur, snap);
        end
      end
      if (bus.out_ready) begin
        stalled = 1'b0;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got %h expected no beat", cur);
        end else begin
          e = exp_q.pop_front();
          chk("beat_v0",   cur.v0,          e.v0);
          chk("beat_v1",   cur.v1,          e.v1);
          chk("beat_be",   64'(cur.be),     64'(e.be));
          chk("beat_sew",  64'(cur.sew),    64'(e.sew));
          chk("beat_idx",  64'(cur.idx),    64'(e.idx));
          chk("beat_last", 64'(cur.last),   64'(e.last));
          chk("beat_err",  64'(cur.err),    64'(e.err));
        end
      end else begin
        snap = cur;
        stalled = 1'b1;
      end
    end else begin
      stalled = 1'b0;
    end
  end

  initial begin
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_flush = 1'b0;
    bus.in_vec0 = '0; bus.in_vec1 = '0; bus.in_sew = '0; bus.in_factor = 1'b0;
    bus.in_signed0 = 1'b0; bus.in_signed1 = 1'b0; bus.in_be = '0;
    acc_ov = 1'b0; acc_last = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_vec0",  bus.out_vec0, 64'd0);
    chk("rst_vec1",  bus.out_vec1, 64'd0);
    chk("rst_ctl",   64'({bus.out_be, bus.out_sew, bus.out_idx, bus.out_last, bus.out_err}), 64'd0);
    rst_n = 1'b1; #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;

    // vf2 sew8: operand 0 signed, operand 1 unsigned
    push(64'hFF89FFABFFCDFFEF, 64'h0076005400320010, 8'hFF, 2'd1, 2'd0, 1'b0, 1'b0);
    push(64'h0001002300450067, 64'h00FE00DC00BA0098, 8'hFF, 2'd1, 2'd1, 1'b1, 1'b0);
    send(64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 2'd0, 1'b0, 1'b1, 1'b0, 8'hFF);
    chk("latency_valid", 64'(bus.out_valid), 64'd1);
    chk("latency_idx",   64'(bus.out_idx),   64'd0);
    drain();

    // Back-to-back: vf2 word followed by vf4 word with in_valid held
    push(64'hFF89FFABFFCDFFEF, 64'h0076005400320010, 8'hFF, 2'd1, 2'd0, 1'b0, 1'b0);
    push(64'h0001002300450067, 64'h00FE00DC00BA0098, 8'hFF, 2'd1, 2'd1, 1'b1, 1'b0);
    push(64'h000000CD000000EF, 64'hFFFFFFCDFFFFFFEF, 8'hFF, 2'd2, 2'd0, 1'b0, 1'b0);
    push(64'h00000089000000AB, 64'hFFFFFF89FFFFFFAB, 8'h00, 2'd2, 2'd1, 1'b0, 1'b0);
    push(64'h0000004500000067, 64'h0000004500000067, 8'hFF, 2'd2, 2'd2, 1'b0, 1'b0);
    push(64'h0000000100000023, 64'h0000000100000023, 8'hFF, 2'd2, 2'd3, 1'b1, 1'b0);
    send(64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 2'd0, 1'b0, 1'b1, 1'b0, 8'hFF);
    send(64'h0123456789ABCDEF, 64'h0123456789ABCDEF, 2'd0, 1'b1, 1'b0, 1'b1, 8'hF3);
    chk("b2b_accept_in_last", 64'({acc_ov, acc_last}), 64'd3);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("b2b_no_bubble", 64'(bus.out_valid), 64'd1);
    end
    drain();

    // Random output stalls over several widths plus illegal combinations
    rdy_mode = 1;
    push(64'h00001234FFFFF00D, 64'h0, 8'hFF, 2'd2, 2'd0, 1'b0, 1'b0);
    push(64'hFFFF800000007FFF, 64'h0, 8'h00, 2'd2, 2'd1, 1'b1, 1'b0);
    send(64'h80007FFF1234F00D, 64'h0, 2'd1, 1'b0, 1'b1, 1'b1, 8'h0F);
    push(64'h00000000CAFEBABE, 64'hFFFFFFFFCAFEBABE, 8'h03, 2'd3, 2'd0, 1'b0, 1'b0);
    push(64'h00000000DEADBEEF, 64'hFFFFFFFFDEADBEEF, 8'hC0, 2'd3, 2'd1, 1'b1, 1'b0);
    send(64'hDEADBEEFCAFEBABE, 64'hDEADBEEFCAFEBABE, 2'd2, 1'b0, 1'b0, 1'b1, 8'h81);
    push(64'h0000000000007FFF, 64'h000000000000FFFF, 8'hFF, 2'd3, 2'd0, 1'b0, 1'b0);
    push(64'hFFFFFFFFFFFF8000, 64'h0, 8'hFF, 2'd3, 2'd1, 1'b0, 1'b0);
    push(64'h0000000000000001, 64'h0, 8'hFF, 2'd3, 2'd2, 1'b0, 1'b0);
    push(64'hFFFFFFFFFFFFFFFF, 64'h0, 8'hFF, 2'd3, 2'd3, 1'b1, 1'b0);
    send(64'hFFFF000180007FFF, 64'h000000000000FFFF, 2'd1, 1'b1, 1'b1, 1'b0, 8'hFF);
    push(64'h0, 64'h0, 8'h00, 2'd3, 2'd0, 1'b1, 1'b1);
    send(64'h0123456789ABCDEF, 64'h0123456789ABCDEF, 2'd3, 1'b0, 1'b1, 1'b1, 8'hFF);
    push(64'h0, 64'h0, 8'h00, 2'd2, 2'd0, 1'b1, 1'b1);
    send(64'h0123456789ABCDEF, 64'h0123456789ABCDEF, 2'd2, 1'b1, 1'b1, 1'b1, 8'hFF);
    drain();
    rdy_mode = 0;
    repeat (2) @(posedge clk); #1;

    // Flush while idx=1 of a vf4 word, then a full word must restart at idx 0
    push(64'h000000CD000000EF, 64'h0, 8'hFF, 2'd2, 2'd0, 1'b0, 1'b0);
    send(64'h0123456789ABCDEF, 64'h0, 2'd0, 1'b1, 1'b0, 1'b0, 8'hFF);
    @(posedge clk); #1;
    chk("flush_at_idx", 64'(bus.out_idx), 64'd1);
    bus.in_flush = 1'b1; #1;
    chk("flush_in_ready", 64'(bus.in_ready), 64'd0);
    @(posedge clk); #1;
    bus.in_flush = 1'b0;
    chk("flush_valid", 64'(bus.out_valid), 64'd0);
    chk("flush_idx",   64'(bus.out_idx),   64'd0);
    chk("flush_queue", 64'(exp_q.size()),  64'd0);
    push(64'h000000CD000000EF, 64'hFFFFFFCDFFFFFFEF, 8'hFF, 2'd2, 2'd0, 1'b0, 1'b0);
    push(64'h00000089000000AB, 64'hFFFFFF89FFFFFFAB, 8'h00, 2'd2, 2'd1, 1'b0, 1'b0);
    push(64'h0000004500000067, 64'h0000004500000067, 8'hFF, 2'd2, 2'd2, 1'b0, 1'b0);
    push(64'h0000000100000023, 64'h0000000100000023, 8'hFF, 2'd2, 2'd3, 1'b1, 1'b0);
    send(64'h0123456789ABCDEF, 64'h0123456789ABCDEF, 2'd0, 1'b1, 1'b0, 1'b1, 8'hF3);
    drain();

    // Asynchronous reset in mid-word
    push(64'h000000CD000000EF, 64'h0, 8'hFF, 2'd2, 2'd0, 1'b0, 1'b0);
    send(64'h0123456789ABCDEF, 64'h0, 2'd0, 1'b1, 1'b0, 1'b0, 8'hFF);
    @(posedge clk); #1;
    rst_n = 1'b0; #1;
    chk("midrst_valid", 64'(bus.out_valid), 64'd0);
    chk("midrst_vec0",  bus.out_vec0, 64'd0);
    chk("midrst_ctl",   64'({bus.out_be, bus.out_sew, bus.out_idx, bus.out_last, bus.out_err}), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; #1;
    chk("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midrst_no_beat", 64'(bus.out_valid), 64'd0);
    end
    chk("midrst_queue", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/vwiden_seq.md
# vwiden_seq

Sequenced operand-widening stage for the vALU front end. It accepts one beat of two source operands and emits them as 2 (vf2) or 4 (vf4) consecutive widened beats. Each source element is sign- or zero-extended to 2×/4× SEW. Valid/ready handshakes on both sides let it sit between operand fetch and the widening arithmetic units. It supersedes the single-cycle, 64-bit, 2×-only widening path with one that is width-parametrised, supports 4× extension, and generates beats itself.

## Interface
- DATA_WIDTH, 64, operand width in bits; multiple of 32, ≥32
- SEW_WIDTH, 2, SEW encoding width (0=8b, 1=16b, 2=32b, 3=64b)
- BE_WIDTH, DATA_WIDTH/8, byte-enable width
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  source beat valid
- in_ready  out  1  source beat accepted when in_valid & in_ready
- in_vec0, in_vec1  in  DATA_WIDTH  source operands
- in_sew  in  SEW_WIDTH  source element width
- in_factor  in  1  0 = ×2 (vf2), 1 = ×4 (vf4)
- in_signed0, in_signed1  in  1  sign-extend operand 0/1 when 1, zero-extend when 0
- in_be  in  BE_WIDTH  source byte enables
- in_flush  in  1  synchronous abort of the beat in progress
- out_valid  out  1  widened beat valid
- out_ready  in  1  downstream accepts when out_valid & out_ready
- out_vec0, out_vec1  out  DATA_WIDTH  widened operands
- out_be  out  BE_WIDTH  widened byte enables
- out_sew  out  SEW_WIDTH  in_sew + log2(F)
- out_idx  out  2  beat index within the source word (0..F-1)
- out_last  out  1  final beat of the source word
- out_err  out  1  illegal widening (in_sew + log2(F) > 3)

## Operation
- F = 2 when in_factor = 0, and F = 4 when in_factor = 1. Slice width S = DATA_WIDTH/F.
- On accept, the block captures vec0, vec1, sew, factor, signed flags and be into holding registers.
- States:
  - IDLE: out_valid=0, in_ready=1. An accept moves to EMIT with idx=0.
  - EMIT: out_valid=1. A handshake with idx<F-1 increments idx. A handshake with idx=F-1 returns to IDLE, or stays in EMIT with idx=0 if a new source beat is accepted in the same cycle.
- in_ready = (state==IDLE) | (out_valid & out_ready & out_last). This gives back-to-back words with no bubble.
- Beat k output data:
  - Source slice is bits [k·S +: S].
  - Each SEW element in the slice is extended to SEW·F bits, using its MSB when signed, or zeros otherwise.
  - Element order is preserved, so the lowest element is in the low bits.
- Beat k byte enables: each byte-enable bit in the slice [k·S/8 +: S/8] is replicated F times.
- Illegal combination (sew+log2F > 3):
  - Accepted normally.
  - Emits exactly one beat with out_err=1, data=0, be=0, out_last=1, out_sew=in_sew.
- in_flush:
  - Forces IDLE and idx=0 at the next edge. Any out handshake in that cycle is void.
  - in_ready is 0 during flush, so a new source beat cannot be accepted in the flush cycle.
- Reset state: IDLE, idx=0, all outputs 0, and holding registers cleared.

## Timing
- Latency: the first widened beat appears the cycle after accept. Its output is registered.
- Throughput: one output beat per cycle while out_ready=1, so a source word takes F cycles.
- Outputs hold stable while out_valid & !out_ready (stall). idx does not advance.
- Asserting rst_n low in mid-word drops the word immediately. No partial beat is emitted after reset release.
- If in_flush and an out handshake occur together, the flush wins.

## Structure
- The shared vALU package holds:
  - SEW encoding constants
  - the state enum {IDLE, EMIT}
  - a function log2_factor(in_factor)
- One natural sub-module, vwiden_slice: a combinational function of (slice, sew, factor, signed) producing DATA_WIDTH, instantiated twice (one per operand).
- Beat control, holding registers and the byte-enable mux stay in the top level.

## Test plan
- vf2, signed0=1, sew=0, in_vec0=0x0123456789ABCDEF, out_ready=1:
  - beat0 = 0xFF89FFABFFCDFFEF (idx0, out_sew=1)
  - beat1 = 0x0001002300450067 (idx1, last=1)
- vf4, sew=0, in_vec0=0x0123456789ABCDEF, in_be=0xF3:
  - unsigned beat0 = 0x000000CD000000EF; signed beat0 = 0xFFFFFFCDFFFFFFEF
  - beat3 = 0x0000000100000023
  - out_be = 0xFF, 0x00, 0xFF, 0xFF across beats 0..3
  - out_sew = 2
- Back-to-back words with in_valid held high:
  - second word accepted in the beat with last=1
  - no idle cycle between the two words' beats
  - in_ready=0 on all non-last beats
- Stalls: out_ready toggled randomly.
  - Outputs are stable while stalled.
  - No beat is lost or duplicated; idx sequence is exactly 0..F-1.
- Illegal case: sew=3 with vf2, then sew=2 with vf4 → each gives a single beat with out_err=1, data 0, be 0, last=1.
- Abort cases:
  - in_flush at idx=1 of a vf4 word → IDLE next cycle, out_valid=0, next word restarts at idx0.
  - rst_n pulsed low in mid-word → all outputs 0 immediately, in_ready=1 after release.
